// File: rtl/c906_icg_idle_ctrl.sv
// c906_icg_idle_ctrl
// Enable controller for one gated_clk_cell instance. Merges requester wake
// requests with the domain busy flag. Drives the cell's external_en. Turns the
// gated clock off after a programmable idle hold-off. Runs on the ungated
// forever_cpuclk.
// Optional build macro: C906_ICG_CTRL_STAT_EN adds the gated_cyc_cnt counter
// and its port.
module c906_icg_idle_ctrl #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDLE_W = 4
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   ack,
    input  logic              domain_busy,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic              icg_external_en,
`ifdef C906_ICG_CTRL_STAT_EN
    output logic              clk_on,
    output logic [31:0]       gated_cyc_cnt
`else
    output logic              clk_on
`endif
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t              state;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                wake;

    // Any requester or in-flight work keeps the gated clock alive
    always_comb begin
        wake = (|req) | domain_busy;
    end

    // Control FSM. Enable and clk_on are registered from the next state so they
    // change on the same edge as the state.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state           <= ST_OFF;
            idle_cnt        <= '0;
            icg_external_en <= 1'b0;
            clk_on          <= 1'b0;
            ack             <= '0;
        end else begin
            ack <= req & {NREQ{state == ST_ON}};
            case (state)
                ST_OFF: begin
                    if (wake) begin
                        state           <= ST_WAKE;
                        icg_external_en <= 1'b1;
                    end else begin
                        icg_external_en <= 1'b0;
                    end
                    clk_on <= 1'b0;
                end
                ST_WAKE: begin
                    state           <= ST_ON;
                    icg_external_en <= 1'b1;
                    clk_on          <= 1'b1;
                end
                ST_ON: begin
                    icg_external_en <= 1'b1;
                    if (!wake) begin
                        state    <= ST_IDLE;
                        idle_cnt <= idle_thresh;
                        clk_on   <= 1'b0;
                    end else begin
                        clk_on   <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    // A wake request wins over an expired hold-off.
                    if (wake) begin
                        state           <= ST_ON;
                        idle_cnt        <= '0;
                        icg_external_en <= 1'b1;
                        clk_on          <= 1'b1;
                    end else if (idle_cnt == '0) begin
                        state           <= ST_OFF;
                        icg_external_en <= 1'b0;
                        clk_on          <= 1'b0;
                    end else begin
                        idle_cnt        <= idle_cnt - 1'b1;
                        icg_external_en <= 1'b1;
                        clk_on          <= 1'b0;
                    end
                end
                default: begin
                    state           <= ST_OFF;
                    idle_cnt        <= '0;
                    icg_external_en <= 1'b0;
                    clk_on          <= 1'b0;
                end
            endcase
        end
    end

`ifdef C906_ICG_CTRL_STAT_EN
    // Saturating count of cycles spent with the gated clock off
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            gated_cyc_cnt <= '0;
        end else if (state == ST_OFF && gated_cyc_cnt != '1) begin
            gated_cyc_cnt <= gated_cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_c906_icg_idle_ctrl.sv
// Directed self-checking bench for c906_icg_idle_ctrl.
// With C906_ICG_CTRL_STAT_EN defined, it also checks gated_cyc_cnt.
module tb_c906_icg_idle_ctrl;

    logic        forever_cpuclk;
    logic        cpurst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        domain_busy;
    logic [3:0]  idle_thresh;
    logic        icg_external_en;
    logic        clk_on;
`ifdef C906_ICG_CTRL_STAT_EN
    logic [31:0] gated_cyc_cnt;
`endif

    int unsigned checks;
    int unsigned errors;

    c906_icg_idle_ctrl #(.NREQ(4), .IDLE_W(4)) dut (
        .forever_cpuclk  (forever_cpuclk),
        .cpurst          (cpurst),
        .req             (req),
        .ack             (ack),
        .domain_busy     (domain_busy),
        .idle_thresh     (idle_thresh),
        .icg_external_en (icg_external_en),
`ifdef C906_ICG_CTRL_STAT_EN
        .clk_on          (clk_on),
        .gated_cyc_cnt   (gated_cyc_cnt)
`else
        .clk_on          (clk_on)
`endif
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the three visible outputs at once
    task automatic chk3(input string tag, input logic en, input logic on, input logic [3:0] a);
        chk({tag, "_en"},  {31'd0, icg_external_en}, {31'd0, en});
        chk({tag, "_on"},  {31'd0, clk_on},          {31'd0, on});
        chk({tag, "_ack"}, {28'd0, ack},             {28'd0, a});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cpurst      = 1'b1;
        req         = 4'b0000;
        domain_busy = 1'b0;
        idle_thresh = 4'd0;

        // Reset, then 10 idle cycles
        step();
        step();
        chk3("reset", 1'b0, 1'b0, 4'b0000);
        chk("reset_idle_cnt", {28'd0, dut.idle_cnt}, 32'd0);
        cpurst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk3("idle_off", 1'b0, 1'b0, 4'b0000);
        end
`ifdef C906_ICG_CTRL_STAT_EN
        chk("stat_10", gated_cyc_cnt, 32'd10);
`endif

        // Cold wake with a single requester
        req = 4'b0010;
        step(); chk3("cold_e1", 1'b1, 1'b0, 4'b0000);
        step(); chk3("cold_e2", 1'b1, 1'b1, 4'b0000);
        step(); chk3("cold_e3", 1'b1, 1'b1, 4'b0010);

        // New request while ON: ack one edge later, no priority among bits
        req = 4'b1011;
        step(); chk3("on_req", 1'b1, 1'b1, 4'b1011);

        // Idle hold-off with thresh 3: four IDLE cycles, then off
        idle_thresh = 4'd3;
        req = 4'b0000;
        step(); chk3("hold_i0", 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(); chk3("hold_i", 1'b1, 1'b0, 4'b0000);
        end
        step(); chk3("hold_off", 1'b0, 1'b0, 4'b0000);

        // Re-wake race: request arrives in the IDLE cycle with idle_cnt==0
        req = 4'b0001;
        step(); step(); step();
        chk3("race_on", 1'b1, 1'b1, 4'b0001);
        idle_thresh = 4'd2;
        req = 4'b0000;
        step(); chk("race_cnt2", {28'd0, dut.idle_cnt}, 32'd2);
        step();
        step(); chk("race_cnt0", {28'd0, dut.idle_cnt}, 32'd0);
        chk3("race_idle", 1'b1, 1'b0, 4'b0000);
        req = 4'b0001;
        step(); chk3("race_back_on", 1'b1, 1'b1, 4'b0000);
        step(); chk3("race_ack", 1'b1, 1'b1, 4'b0001);

        // Back to OFF with thresh 0 (exactly one IDLE cycle)
        idle_thresh = 4'd0;
        req = 4'b0000;
        step(); chk3("t0_idle", 1'b1, 1'b0, 4'b0000);
        step(); chk3("t0_off", 1'b0, 1'b0, 4'b0000);

        // Busy alone keeps the clock running, no acks
        domain_busy = 1'b1;
        step(); chk3("busy_wake", 1'b1, 1'b0, 4'b0000);
        step(); chk3("busy_on", 1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 18; i++) begin
            step(); chk3("busy_hold", 1'b1, 1'b1, 4'b0000);
        end
        domain_busy = 1'b0;
        step(); chk3("busy_idle", 1'b1, 1'b0, 4'b0000);
        step(); chk3("busy_off", 1'b0, 1'b0, 4'b0000);

        // Request raised right after entering OFF is seen on the next edge
        req = 4'b0100;
        step(); chk3("reoff_wake", 1'b1, 1'b0, 4'b0000);
        step(); chk3("reoff_on", 1'b1, 1'b1, 4'b0000);

        // Reset mid-IDLE with idle_cnt == 5
        idle_thresh = 4'd5;
        req = 4'b0000;
        step(); chk("mid_cnt5", {28'd0, dut.idle_cnt}, 32'd5);
        chk3("mid_idle", 1'b1, 1'b0, 4'b0000);
        cpurst = 1'b1;
        req = 4'b1111;
        step(); chk3("mid_rst", 1'b0, 1'b0, 4'b0000);
        chk("mid_rst_cnt", {28'd0, dut.idle_cnt}, 32'd0);
`ifdef C906_ICG_CTRL_STAT_EN
        chk("mid_rst_stat", gated_cyc_cnt, 32'd0);
`endif
        cpurst = 1'b0;
        req = 4'b0000;
        step(); chk3("post_rst", 1'b0, 1'b0, 4'b0000);
`ifdef C906_ICG_CTRL_STAT_EN
        chk("post_rst_stat", gated_cyc_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c906_icg_idle_ctrl.md
# c906_icg_idle_ctrl

Clock-gating enable controller for one `gated_clk_cell` instance. It arbitrates wake requests from up to `NREQ` requesters and the domain's own busy indication, and drives the cell's `external_en`. After the gated domain has been idle for a programmable number of cycles, the controller turns the gated clock off. It sits beside the ICG in the clock-gating layer, on the ungated `forever_cpuclk`.

## Interface
Parameters:
- `NREQ`, 4, number of wake requesters (1..8)
- `IDLE_W`, 4, width of the idle hold-off counter

Ports:
- `forever_cpuclk`  in  1  ungated free-running clock; all state sampled on its rising edge
- `cpurst`  in  1  reset, synchronous, active-high
- `req`  in  NREQ  per-requester level request for the gated clock; held until done
- `ack`  out  NREQ  per-requester grant: gated clock is running for this requester
- `domain_busy`  in  1  gated domain has work in flight; blocks gating
- `idle_thresh`  in  IDLE_W  idle cycles to wait before gating
- `icg_external_en`  out  1  to `gated_clk_cell.external_en`, registered
- `clk_on`  out  1  high in ON state (informational)
- `gated_cyc_cnt`  out  32  cycles spent in OFF; present only with `C906_ICG_CTRL_STAT_EN`

## Operation
Definition: `wake = |req | domain_busy`.

FSM states: OFF, WAKE, ON, IDLE.
- OFF:
  - `icg_external_en`=0.
  - `wake` -> WAKE; otherwise stay in OFF.
- WAKE:
  - `icg_external_en`=1.
  - The ICG latches the enable; the first gated edge arrives at the next `forever_cpuclk` posedge.
  - Always -> ON after one cycle, even if `req` has dropped.
- ON:
  - `icg_external_en`=1, `clk_on`=1.
  - `!wake` -> IDLE, loading `idle_cnt` <= `idle_thresh`.
  - `idle_thresh` is sampled only on this transition.
- IDLE:
  - `icg_external_en`=1; the gated clock is still running.
  - `wake` -> ON, with `idle_cnt` cleared.
  - Else if `idle_cnt`==0 -> OFF.
  - Else `idle_cnt` decrements by 1.

Ack and counter rules:
- `ack` is registered: `ack[i]` <= `req[i]` & (state==ON). Ack drops one cycle after `req[i]` drops, or on leaving ON.
- `idle_cnt` is an IDLE_W-bit unsigned down-counter and never wraps below 0.

## Timing
- Reset values: state OFF, `icg_external_en`=0, `ack`=0, `clk_on`=0, `idle_cnt`=0, `gated_cyc_cnt`=0.
- Reset is taken on any edge with `cpurst`=1, regardless of state. A mid-operation reset gates the clock on the following cycle.
- Wake latency from OFF: `req` high before edge E0 gives:
  - WAKE after E0 (en=1)
  - ON after E1
  - `ack` high after E2
- Request in ON: `ack` is high one edge after `req`.
- Request in IDLE: ON after one edge, `ack` after two edges; no gap in the gated clock.
- Gating latency: ON with `wake`=0 at edge E0 gives IDLE after E0, then OFF after E0+`idle_thresh`+1.
  - `idle_thresh`=0 means exactly one IDLE cycle.
  - Maximum is 2^IDLE_W cycles.
- Simultaneous `wake` and `idle_cnt`==0 in IDLE: wake wins, go to ON.
- `wake` arriving in the same cycle the FSM enters OFF is seen next edge: OFF -> WAKE.
- Requester ordering is irrelevant: every active `req` bit is acked together; there is no priority.

## Configuration
- `C906_ICG_CTRL_STAT_EN` defined:
  - `gated_cyc_cnt` port and a 32-bit counter exist.
  - The counter increments on every edge with state==OFF and saturates at 0xFFFF_FFFF.
  - Cleared by `cpurst`.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then idle:
  - `cpurst`=1 for 2 cycles, then release with all inputs 0 for 10 cycles.
  - Required: `icg_external_en`=0, `ack`=0, gated clock low throughout.
  - With the macro: `gated_cyc_cnt`=10.
- Cold wake:
  - `req`=4'b0010 in OFF.
  - Required: en=1 after 1 edge, `clk_on`=1 after 2, `ack`=4'b0010 after 3, and the gated clock pulses starting at edge 2.
- Idle hold-off:
  - `idle_thresh`=3; drop `req` and `domain_busy` in ON.
  - Required: IDLE for exactly 4 cycles with the clock running, then en=0; `ack` drops one edge after `req`.
- IDLE re-wake race:
  - `idle_thresh`=2; assert `req[0]` in the cycle `idle_cnt`==0.
  - Required: state returns to ON, en never drops, `ack[0]` high two edges later.
- Busy blocks gating:
  - `req`=0, `domain_busy`=1 for 20 cycles from OFF.
  - Required: WAKE then ON, en=1 throughout, `ack`=0; after busy drops and `idle_thresh`=0, en=0 two edges later.
- Reset mid-IDLE:
  - Assert `cpurst` with `idle_cnt`=5.
  - Required: next edge gives state OFF, en=0, `ack`=0, `idle_cnt`=0.
